// File: rtl/btn_event_arbiter.sv
// Debounced multi-button front end: per-channel sync + debounce, press/release
// pending flags, and a round-robin arbiter offering one event at a time.
`timescale 1ns/1ps
module btn_event_arbiter #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int ID_W           = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_type,
    output logic [N_BTN-1:0] btn_level,
    output logic             evt_drop
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ID_W:0]    N_WRAP  = (ID_W + 1)'(N_BTN);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_BTN - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    logic [N_BTN-1:0] s1, s2, deb;
    logic [CNT_W-1:0] cnt [N_BTN];
    logic [N_BTN-1:0] press_set, rel_set, press_clr, rel_clr;
    logic [N_BTN-1:0] press_pend, rel_pend;
    logic [ID_W-1:0]  rr_ptr;
    logic [0:0]       state;
    logic             found;
    logic [ID_W-1:0]  pick_id;
    logic             pick_type;
    logic [ID_W:0]    scan_sum;
    logic [ID_W-1:0]  scan_idx;

    assign btn_level = deb;

    // The debounced level flips on the edge where the count saturates, so the
    // event flags are set from the same condition to land on that edge too.
    always_comb begin
        press_set = '0;
        rel_set   = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if ((s2[i] != deb[i]) && (cnt[i] == CNT_MAX)) begin
                press_set[i] = s2[i];
                rel_set[i]   = ~s2[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1  <= '0;
            s2  <= '0;
            deb <= '0;
            for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
            for (int i = 0; i < N_BTN; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Round-robin scan from rr_ptr; press outranks release within a channel.
    always_comb begin
        found     = 1'b0;
        pick_id   = '0;
        pick_type = 1'b0;
        press_clr = '0;
        rel_clr   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        if (state == ST_IDLE) begin
            for (int k = 0; k < N_BTN; k++) begin
                scan_sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
                if (scan_sum >= N_WRAP) scan_sum = scan_sum - N_WRAP;
                scan_idx = scan_sum[ID_W-1:0];
                if (!found && (press_pend[scan_idx] || rel_pend[scan_idx])) begin
                    found     = 1'b1;
                    pick_id   = scan_idx;
                    pick_type = ~press_pend[scan_idx];
                    if (press_pend[scan_idx]) press_clr[scan_idx] = 1'b1;
                    else                      rel_clr[scan_idx]   = 1'b1;
                end
            end
        end
    end

    // A set always wins over a same-cycle grant; only a set onto a live flag is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            press_pend <= '0;
            rel_pend   <= '0;
            evt_drop   <= 1'b0;
        end else begin
            press_pend <= (press_pend & ~press_clr) | press_set;
            rel_pend   <= (rel_pend & ~rel_clr) | rel_set;
            evt_drop   <= |((press_set & press_pend & ~press_clr) |
                            (rel_set & rel_pend & ~rel_clr));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_type  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        evt_valid <= 1'b1;
                        evt_id    <= pick_id;
                        evt_type  <= pick_type;
                        state     <= ST_OFFER;
                    end
                end
                default: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        rr_ptr    <= (evt_id == LAST_ID) ? '0 : evt_id + 1'b1;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Scoreboard bench for btn_event_arbiter: directed button sequences push expected
// events; a negedge monitor pops and compares on every completed handshake.
`timescale 1ns/1ps
module tb_btn_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_in = 4'b0000;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_type;
    logic [3:0] btn_level;
    logic       evt_drop;

    btn_event_arbiter #(.N_BTN(4), .DEBOUNCE_CYCLES(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_type  (evt_type),
        .btn_level (btn_level),
        .evt_drop  (evt_drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic       typ;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;
    int   seenCount = 0;
    int   dropCount = 0;
    bit   holdBad = 1'b0;
    int   seenBase;
    int   dropBase;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] btn, input logic rdy);
        btn_in    = btn;
        evt_ready = rdy;
    endtask

    task automatic tickN(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tickHold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (!(evt_valid === 1'b1 && evt_id === 2'd1 && evt_type === 1'b0)) holdBad = 1'b1;
        end
    endtask

    task automatic pushExp(input logic [1:0] id, input logic typ);
        exp_t e;
        e.id  = id;
        e.typ = typ;
        expQ.push_back(e);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, int'(evt_valid), 0);
        checkOutput({tag, "_id"},    int'(evt_id), 0);
        checkOutput({tag, "_type"},  int'(evt_type), 0);
        checkOutput({tag, "_level"}, int'(btn_level), 0);
        checkOutput({tag, "_drop"},  int'(evt_drop), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (evt_drop) dropCount++;
            if (evt_valid && evt_ready) begin
                seenCount++;
                total++;
                if (expQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_event: got id=%0d type=%0d, want none",
                             evt_id, evt_type);
                end else begin
                    e = expQ.pop_front();
                    if (evt_id !== e.id || evt_type !== e.typ) begin
                        bad++;
                        $display("[TB] FAIL event_order: got id=%0d type=%0d, want id=%0d type=%0d",
                                 evt_id, evt_type, e.id, e.typ);
                    end
                end
            end
        end
    end

    initial begin
        // reset values
        applyStimulus(4'b0000, 1'b0);
        tickN(3);
        checkAllZero("reset");
        rst_n = 1'b1;
        applyStimulus(4'b0000, 1'b1);
        tickN(2);

        // debounce latency, press then release on channel 2
        applyStimulus(4'b0100, 1'b1);
        pushExp(2'd2, 1'b0);
        tickN(18);
        checkOutput("press_early_valid", int'(evt_valid), 0);
        tickN(1);
        checkOutput("press_valid", int'(evt_valid), 1);
        checkOutput("press_id", int'(evt_id), 2);
        checkOutput("press_type", int'(evt_type), 0);
        checkOutput("press_level", int'(btn_level), 4);
        tickN(81);
        applyStimulus(4'b0000, 1'b1);
        pushExp(2'd2, 1'b1);
        tickN(18);
        checkOutput("rel_early_valid", int'(evt_valid), 0);
        tickN(1);
        checkOutput("rel_valid", int'(evt_valid), 1);
        checkOutput("rel_id", int'(evt_id), 2);
        checkOutput("rel_type", int'(evt_type), 1);
        tickN(5);

        // glitch rejection on channel 1
        seenBase = seenCount;
        for (int i = 0; i < 40; i++) begin
            #($urandom_range(3, 20));
            btn_in[1] = 1'($urandom_range(0, 1));
        end
        btn_in[1] = 1'b0;
        @(posedge clk);
        #1;
        tickN(30);
        checkOutput("glitch_level", int'(btn_level), 0);
        checkOutput("glitch_events", seenCount - seenBase, 0);

        // 15-cycle pulse rejected, 16-cycle pulse accepted on channel 3
        seenBase = seenCount;
        applyStimulus(4'b1000, 1'b1);
        tickN(15);
        applyStimulus(4'b0000, 1'b1);
        tickN(30);
        checkOutput("pulse15_events", seenCount - seenBase, 0);
        pushExp(2'd3, 1'b0);
        pushExp(2'd3, 1'b1);
        applyStimulus(4'b1000, 1'b1);
        tickN(16);
        applyStimulus(4'b0000, 1'b1);
        tickN(40);
        checkOutput("pulse16_events", seenCount - seenBase, 2);
        checkOutput("pulse16_level", int'(btn_level), 0);

        // round robin starting from pointer 0
        applyStimulus(4'b1011, 1'b0);
        pushExp(2'd0, 1'b0);
        pushExp(2'd1, 1'b0);
        pushExp(2'd3, 1'b0);
        tickN(25);
        checkOutput("rr0_first_id", int'(evt_id), 0);
        applyStimulus(4'b1011, 1'b1);
        tickN(10);
        pushExp(2'd0, 1'b1);
        pushExp(2'd1, 1'b1);
        pushExp(2'd3, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        tickN(30);

        // move the pointer to 2 with a channel 1 press/release, then repeat
        pushExp(2'd1, 1'b0);
        applyStimulus(4'b0010, 1'b1);
        tickN(25);
        pushExp(2'd1, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        tickN(25);
        applyStimulus(4'b1011, 1'b0);
        pushExp(2'd3, 1'b0);
        pushExp(2'd0, 1'b0);
        pushExp(2'd1, 1'b0);
        tickN(25);
        checkOutput("rr2_first_id", int'(evt_id), 3);
        applyStimulus(4'b1011, 1'b1);
        tickN(10);
        pushExp(2'd3, 1'b1);
        pushExp(2'd0, 1'b1);
        pushExp(2'd1, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        tickN(30);

        // backpressure and drop on channel 1
        dropBase = dropCount;
        applyStimulus(4'b0010, 1'b0);
        tickN(20);
        checkOutput("bp_valid", int'(evt_valid), 1);
        checkOutput("bp_id", int'(evt_id), 1);
        checkOutput("bp_type", int'(evt_type), 0);
        applyStimulus(4'b0000, 1'b0);
        tickHold(20);
        applyStimulus(4'b0010, 1'b0);
        tickHold(20);
        checkOutput("bp_press2_drops", dropCount - dropBase, 0);
        applyStimulus(4'b0000, 1'b0);
        tickHold(20);
        checkOutput("bp_rel2_drops", dropCount - dropBase, 1);
        applyStimulus(4'b0010, 1'b0);
        tickHold(20);
        checkOutput("bp_press3_drops", dropCount - dropBase, 2);
        checkOutput("bp_hold_stable", int'(holdBad), 0);
        pushExp(2'd1, 1'b0);
        pushExp(2'd1, 1'b0);
        pushExp(2'd1, 1'b1);
        applyStimulus(4'b0010, 1'b1);
        tickN(10);
        pushExp(2'd1, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        tickN(25);

        // new press on channel 0 lands on the edge its pending flag is granted
        dropBase = dropCount;
        pushExp(2'd2, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        tickN(25);
        applyStimulus(4'b0101, 1'b0);
        tickN(25);
        applyStimulus(4'b0100, 1'b0);
        tickN(25);
        pushExp(2'd0, 1'b0);
        pushExp(2'd0, 1'b0);
        pushExp(2'd0, 1'b1);
        applyStimulus(4'b0101, 1'b0);
        tickN(16);
        applyStimulus(4'b0101, 1'b1);
        tickN(30);
        checkOutput("setclr_drops", dropCount - dropBase, 0);
        pushExp(2'd2, 1'b1);
        pushExp(2'd0, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        tickN(30);

        // reset while an event is offered, button 0 held through it
        applyStimulus(4'b0001, 1'b0);
        tickN(25);
        checkOutput("rstoffer_valid", int'(evt_valid), 1);
        rst_n = 1'b0;
        tickN(1);
        checkAllZero("rstoffer");
        rst_n = 1'b1;
        tickN(18);
        checkOutput("rearm_early_valid", int'(evt_valid), 0);
        tickN(1);
        checkOutput("rearm_valid", int'(evt_valid), 1);
        checkOutput("rearm_id", int'(evt_id), 0);
        checkOutput("rearm_type", int'(evt_type), 0);
        pushExp(2'd0, 1'b0);
        applyStimulus(4'b0001, 1'b1);
        tickN(3);
        pushExp(2'd0, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        tickN(25);

        checkOutput("queue_empty", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
